// File: rtl/ysyx_040978_mdu_pkg.sv
// ysyx_040978_mdu_pkg
//   Shared definitions for the RV64M mul/div sequencer.
//   - op encodings MUL..REMU (3-bit)
//   - sequencer state encoding
//   - is_div / is_signed helpers
//   - XLEN_MIN: most negative 64-bit two's-complement value
package ysyx_040978_mdu_pkg;

  localparam int MDU_XLEN = 64;
  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] OP_MUL    = 3'd0;
  localparam logic [MDU_OP_W-1:0] OP_MULH   = 3'd1;
  localparam logic [MDU_OP_W-1:0] OP_MULHU  = 3'd2;
  localparam logic [MDU_OP_W-1:0] OP_MULHSU = 3'd3;
  localparam logic [MDU_OP_W-1:0] OP_DIV    = 3'd4;
  localparam logic [MDU_OP_W-1:0] OP_DIVU   = 3'd5;
  localparam logic [MDU_OP_W-1:0] OP_REM    = 3'd6;
  localparam logic [MDU_OP_W-1:0] OP_REMU   = 3'd7;

  localparam logic [MDU_XLEN-1:0] XLEN_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } mdu_state_t;

  // DIV, DIVU, REM, REMU
  function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
    return op[2];
  endfunction

  // Ops that interpret rs1 as signed: MULH, MULHSU, DIV, REM
  function automatic logic is_signed(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV)  || (op == OP_REM);
  endfunction

  // REM / REMU (quotient vs remainder select inside the div group)
  function automatic logic is_rem(input logic [MDU_OP_W-1:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/ysyx_040978_mdu_special.sv
// ysyx_040978_mdu_special
//   Combinational detection of div/rem cases that need no iterative core:
//   divide-by-zero and signed overflow (MIN / -1), plus their result.
// Ports
//   i_op       op encoding
//   i_src1     rs1
//   i_src2     rs2
//   o_special  1 when the op is resolved here
//   o_result   architectural result for the special case (valid with o_special)
module ysyx_040978_mdu_special
  import ysyx_040978_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int OP_W = MDU_OP_W
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_special,
  output logic [XLEN-1:0] o_result
);

  logic            w_div;
  logic            w_rem;
  logic            w_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_min;

  assign w_min  = {1'b1, {(XLEN-1){1'b0}}};
  assign w_div  = is_div(i_op);
  assign w_rem  = is_rem(i_op);
  assign w_zero = (i_src2 == '0);
  // Only the signed div/rem ops can overflow
  assign w_ovf  = w_div & is_signed(i_op) & (i_src1 == w_min) & (i_src2 == '1);

  assign o_special = w_div & (w_zero | w_ovf);

  always_comb begin
    o_result = '0;
    if (w_zero) begin
      o_result = w_rem ? i_src1 : '1;
    end else if (w_ovf) begin
      o_result = w_rem ? '0 : i_src1;
    end
  end

endmodule

// File: rtl/ysyx_040978_mdu_ctrl.sv
// ysyx_040978_mdu_ctrl
//   Sequencer between EX and an iterative mul/div core. Accepts one op via
//   in_valid/in_ready, launches the core (or resolves div special cases
//   locally), and holds the result until writeback takes it.
// Ports
//   clock, reset             rising-edge clock, async active-high reset
//   flush                    kill current op (highest priority)
//   in_valid/in_ready        op handshake (ready only in IDLE)
//   in_op/in_src1/in_src2    op and operands
//   core_start/core_kill     one-cycle launch / abort pulses
//   core_op/core_src1/2      registered operands, stable while core runs
//   core_done/core_result    core completion pulse and result
//   out_valid/out_ready      result handshake to writeback
//   out_result               registered result
//   busy                     state != IDLE
module ysyx_040978_mdu_ctrl
  import ysyx_040978_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int OP_W = MDU_OP_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            core_start,
  output logic            core_kill,
  output logic [OP_W-1:0] core_op,
  output logic [XLEN-1:0] core_src1,
  output logic [XLEN-1:0] core_src2,
  input  logic            core_done,
  input  logic [XLEN-1:0] core_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  mdu_state_t      r_state;
  logic            r_core_start;
  logic            r_core_kill;
  logic            r_out_valid;
  logic [OP_W-1:0] r_op;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_src2;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_special;
  logic [XLEN-1:0] w_special_result;

  // Special-case detection looks at the incoming operands so the result can
  // be registered on the accept edge (1-cycle latency).
  ysyx_040978_mdu_special #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_special (
    .i_op      (in_op),
    .i_src1    (in_src1),
    .i_src2    (in_src2),
    .o_special (w_special),
    .o_result  (w_special_result)
  );

  assign w_accept = (r_state == ST_IDLE) & in_valid & ~flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_core_start <= 1'b0;
      r_core_kill  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_op         <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_result     <= '0;
    end else begin
      r_core_start <= 1'b0;
      r_core_kill  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= in_op;
            r_src1 <= in_src1;
            r_src2 <= in_src2;
            if (w_special) begin
              r_result    <= w_special_result;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end else begin
              r_core_start <= 1'b1;
              r_state      <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // flush wins over a coincident core_done: the result is dropped
          if (flush) begin
            r_core_kill <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (core_done) begin
            r_result    <= core_result;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (flush || out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign core_start = r_core_start;
  assign core_kill  = r_core_kill;
  assign core_op    = r_op;
  assign core_src1  = r_src1;
  assign core_src2  = r_src2;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;

endmodule

// File: tb/tb_ysyx_040978_mdu_ctrl.sv
module tb_ysyx_040978_mdu_ctrl;

  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic        core_start;
  logic        core_kill;
  logic [2:0]  core_op;
  logic [63:0] core_src1;
  logic [63:0] core_src2;
  logic        core_done = 1'b0;
  logic [63:0] core_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_start = 0;
  int n_kill  = 0;
  int n_both  = 0;

  ysyx_040978_mdu_ctrl #(.XLEN(64), .OP_W(3)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2),
    .core_start(core_start), .core_kill(core_kill), .core_op(core_op),
    .core_src1(core_src1), .core_src2(core_src2),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (core_start) n_start++;
    if (core_kill)  n_kill++;
    if (core_start && core_kill) n_both++;
  end

  // Architectural RV64M result from plain arithmetic
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb, sq;
    sa = a; sb = b;
    case (op)
      3'd0: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      3'd3: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      3'd4: begin
        if (b == 0) return ALL1;
        if (a == MIN && b == ALL1) return a;
        sq = sa / sb; return sq;
      end
      3'd5: return (b == 0) ? ALL1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == ALL1) return 64'd0;
        sq = sa % sb; return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    return (op >= 3'd4) && ((b == 0) || ((op == 3'd4 || op == 3'd6) && a == MIN && b == ALL1));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Issue one op from IDLE (called at a negedge), play the core with `lat`
  // RUN cycles before core_done, keep out_ready low for `hold` cycles.
  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int lat, input int hold);
    logic [63:0] exp;
    bit          sp;
    int          s0;
    exp = ref_res(op, a, b);
    sp  = is_special(op, a, b);
    s0  = n_start;
    chk("idle_ready", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    cyc();
    in_valid = 1'b0; in_src1 = ~a; in_src2 = ~b;
    if (sp) begin
      chk("sp_valid", {63'b0, out_valid}, 64'd1);
      chk("sp_nostart", {63'b0, core_start}, 64'd0);
      chk("sp_result", out_result, exp);
    end else begin
      for (int k = 0; k <= lat; k++) begin
        chk("run_start", {63'b0, core_start}, (k == 0) ? 64'd1 : 64'd0);
        chk("run_noval", {63'b0, out_valid}, 64'd0);
        chk("run_op", {61'b0, core_op}, {61'b0, op});
        chk("run_src1", core_src1, a);
        chk("run_src2", core_src2, b);
        if (k == lat) begin
          core_done = 1'b1; core_result = exp;
        end
        cyc();
      end
      core_done = 1'b0; core_result = $urandom;
      chk("core_valid", {63'b0, out_valid}, 64'd1);
      chk("core_result", out_result, exp);
      chk("start_count", n_start - s0, 64'd1);
    end
    if (sp) chk("sp_startcnt", n_start - s0, 64'd0);
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("hold_valid", {63'b0, out_valid}, 64'd1);
      chk("hold_result", out_result, exp);
      chk("hold_noready", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("wb_done_valid", {63'b0, out_valid}, 64'd0);
    chk("wb_done_ready", {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    int          k0;

    // Reset values
    #2;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_start", {63'b0, core_start}, 64'd0);
    chk("rst_kill", {63'b0, core_kill}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_src1", core_src1, 64'd0);
    #10 reset = 1'b0;
    @(negedge clock);

    // Directed cases
    do_op(3'd0, 64'd3, 64'd5, 4, 0);
    do_op(3'd5, 64'd7, 64'd0, 0, 0);
    do_op(3'd7, 64'd7, 64'd0, 0, 0);
    do_op(3'd4, MIN, ALL1, 0, 0);
    do_op(3'd6, MIN, ALL1, 0, 0);
    do_op(3'd5, MIN, ALL1, 1, 0);   // unsigned: not special
    do_op(3'd0, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 1, 5);
    do_op(3'd1, ALL1, 64'd2, 0, 0); // core_done in the start cycle

    // Flush in RUN, coincident with core_done, then a late core_done
    k0 = n_kill;
    in_valid = 1'b1; in_op = 3'd5; in_src1 = 64'd100; in_src2 = 64'd7;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    flush = 1'b1; core_done = 1'b1; core_result = 64'd14;
    cyc();
    flush = 1'b0; core_done = 1'b0;
    chk("fl_kill", {63'b0, core_kill}, 64'd1);
    chk("fl_noval", {63'b0, out_valid}, 64'd0);
    chk("fl_ready", {63'b0, in_ready}, 64'd1);
    chk("fl_busy", {63'b0, busy}, 64'd0);
    core_done = 1'b1; core_result = 64'hdead;
    cyc();
    core_done = 1'b0;
    chk("late_kill", {63'b0, core_kill}, 64'd0);
    chk("late_noval", {63'b0, out_valid}, 64'd0);
    chk("late_ready", {63'b0, in_ready}, 64'd1);
    chk("kill_count", n_kill - k0, 64'd1);

    // Flush together with out_ready in HOLD
    in_valid = 1'b1; in_op = 3'd4; in_src1 = 64'd9; in_src2 = 64'd0;
    cyc();
    in_valid = 1'b0;
    chk("hfl_valid", {63'b0, out_valid}, 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0; out_ready = 1'b0;
    chk("hfl_drop", {63'b0, out_valid}, 64'd0);
    chk("hfl_ready", {63'b0, in_ready}, 64'd1);
    chk("hfl_nokill", {63'b0, core_kill}, 64'd0);

    // Flush in IDLE blocks accept
    k0 = n_start;
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_src1 = 64'd2; in_src2 = 64'd2;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("ifl_busy", {63'b0, busy}, 64'd0);
    chk("ifl_nostart", n_start - k0, 64'd0);
    chk("ifl_noval", {63'b0, out_valid}, 64'd0);

    // Async reset mid-RUN
    do_op(3'd0, 64'd3, 64'd5, 0, 0);
    in_valid = 1'b1; in_op = 3'd2; in_src1 = 64'd11; in_src2 = 64'd13;
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_start", {63'b0, core_start}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_start", {63'b0, core_start}, 64'd0);
    chk("ar_busy", {63'b0, busy}, 64'd0);
    chk("ar_ready", {63'b0, in_ready}, 64'd1);
    chk("ar_valid", {63'b0, out_valid}, 64'd0);
    chk("ar_result", out_result, 64'd0);
    chk("ar_op", {61'b0, core_op}, 64'd0);
    chk("ar_src1", core_src1, 64'd0);
    chk("ar_src2", core_src2, 64'd0);
    #3 reset = 1'b0;
    @(negedge clock);
    do_op(3'd6, -64'sd7, 64'd2, 2, 0);
    do_op(3'd6, -64'sd7, 64'd2, 0, 1);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: b = 64'd0;
        1: begin a = MIN; b = ALL1; end
        2: begin a = 64'($urandom_range(0, 100)); b = 64'($urandom_range(1, 9)); end
        default: ;
      endcase
      do_op(op, a, b, $urandom_range(0, 5), $urandom_range(0, 3));
    end

    chk("start_kill_overlap", n_both, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
